// File: rtl/brew_pkg.sv
// brew_pkg: shared encodings for the brew sequencer slice.
// State codes, display stage codes, valve bit positions, recipe select
// codes and per-recipe step counts live here so the top and the recipe
// ROM agree on a single definition.
package brew_pkg;

  // Sequencer FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Stage codes shown on the seven-segment display
  localparam logic [2:0] STG_IDLE      = 3'd0;
  localparam logic [2:0] STG_WATER     = 3'd1;
  localparam logic [2:0] STG_COFFEE    = 3'd2;
  localparam logic [2:0] STG_MILK      = 3'd3;
  localparam logic [2:0] STG_CHOCOLATE = 3'd4;
  localparam logic [2:0] STG_DONE      = 3'd5;

  // Valve enable bit positions
  localparam int VALVE_WATER     = 0;
  localparam int VALVE_COFFEE    = 1;
  localparam int VALVE_MILK      = 2;
  localparam int VALVE_CHOCOLATE = 3;

  // coffee_sel codes
  localparam logic [1:0] SEL_ESPRESSO  = 2'd0;
  localparam logic [1:0] SEL_AMERICANO = 2'd1;
  localparam logic [1:0] SEL_LATTE     = 2'd2;
  localparam logic [1:0] SEL_MOCHA     = 2'd3;

  // Number of steps in each recipe: {2,2,3,4}
  function automatic logic [2:0] recipe_len(input logic [1:0] sel);
    logic [2:0] len;
    case (sel)
      SEL_ESPRESSO:  len = 3'd2;
      SEL_AMERICANO: len = 3'd2;
      SEL_LATTE:     len = 3'd3;
      default:       len = 3'd4;
    endcase
    return len;
  endfunction

  // One-hot valve enable for an active stage; idle/done stages open nothing
  function automatic logic [3:0] stage_to_valve(input logic [2:0] stg);
    logic [3:0] v;
    v = 4'b0000;
    case (stg)
      STG_WATER:     v[VALVE_WATER]     = 1'b1;
      STG_COFFEE:    v[VALVE_COFFEE]    = 1'b1;
      STG_MILK:      v[VALVE_MILK]      = 1'b1;
      STG_CHOCOLATE: v[VALVE_CHOCOLATE] = 1'b1;
      default:       v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/brew_recipe_rom.sv
// brew_recipe_rom: combinational recipe table.
// Maps (recipe select, step index) to the stage shown/valve opened, the
// timer duration code for that stage, and whether it is the final step.
module brew_recipe_rom
  import brew_pkg::*;
(
  input  logic [1:0] i_sel,
  input  logic [1:0] i_step,
  output logic [2:0] o_stage,
  output logic [1:0] o_value,
  output logic       o_last
);

  // Recipe lookup; unused (sel, step) combinations fall back to idle/0
  always_comb begin
    o_stage = STG_IDLE;
    o_value = 2'd0;
    case ({i_sel, i_step})
      {SEL_ESPRESSO, 2'd0}:  begin o_stage = STG_WATER;     o_value = 2'd1; end
      {SEL_ESPRESSO, 2'd1}:  begin o_stage = STG_COFFEE;    o_value = 2'd2; end
      {SEL_AMERICANO, 2'd0}: begin o_stage = STG_WATER;     o_value = 2'd3; end
      {SEL_AMERICANO, 2'd1}: begin o_stage = STG_COFFEE;    o_value = 2'd2; end
      {SEL_LATTE, 2'd0}:     begin o_stage = STG_WATER;     o_value = 2'd1; end
      {SEL_LATTE, 2'd1}:     begin o_stage = STG_COFFEE;    o_value = 2'd2; end
      {SEL_LATTE, 2'd2}:     begin o_stage = STG_MILK;      o_value = 2'd3; end
      {SEL_MOCHA, 2'd0}:     begin o_stage = STG_WATER;     o_value = 2'd1; end
      {SEL_MOCHA, 2'd1}:     begin o_stage = STG_COFFEE;    o_value = 2'd2; end
      {SEL_MOCHA, 2'd2}:     begin o_stage = STG_CHOCOLATE; o_value = 2'd1; end
      {SEL_MOCHA, 2'd3}:     begin o_stage = STG_MILK;      o_value = 2'd2; end
      default:               begin o_stage = STG_IDLE;      o_value = 2'd0; end
    endcase
  end

  // Final step of the selected recipe
  assign o_last = ({1'b0, i_step} == (recipe_len(i_sel) - 3'd1));

endmodule

// File: rtl/brew_sequencer.sv
// brew_sequencer: recipe controller between the front-panel buttons and the
// brew timer. Walks the selected recipe one stage at a time: LOAD pulses
// start_timer with the stage duration, RUN holds the valve until the timer
// expiry edge, DONE holds `done` for DONE_CYCLES cycles.
//
// Button and expiry edges are registered (prev + edge flop), so a rising
// input reaches start_timer two cycles later. An expiry edge that lands
// while in LOAD is dropped.
//
// Build option: define CANCEL_EN to enable btn_cancel (rising edge aborts
// LOAD/RUN/DONE back to IDLE). Without it btn_cancel is not used.
//
// Handshake: start_timer is a single-cycle pulse with value valid in the
// same cycle and held unchanged until the stage ends; the timer answers with
// a level on t_expired, of which only the rising edge is consumed.
//
// dbg_state exposes the FSM state for external checkers.
module brew_sequencer
  import brew_pkg::*;
#(
  parameter int DONE_CYCLES = 100_000_000,
  parameter int DONE_W      = 27            // needs 2**DONE_W > DONE_CYCLES
)(
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_cancel,
  input  logic [1:0] coffee_sel,
  input  logic       t_expired,
  output logic       start_timer,
  output logic [1:0] value,
  output logic [3:0] valve,
  output logic [2:0] stage,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam logic [DONE_W-1:0] LP_DONE_MAX = DONE_W'(DONE_CYCLES - 1);

  logic [1:0]        r_state;
  logic [1:0]        r_sel;
  logic [1:0]        r_step;
  logic [DONE_W-1:0] r_done_cnt;
  logic              r_start_prev;
  logic              r_start_edge;
  logic              r_exp_prev;
  logic              r_exp_edge;

  logic [2:0]        w_rom_stage;
  logic [1:0]        w_rom_value;
  logic              w_rom_last;
  logic              w_active;
  logic              w_cancel;

  brew_recipe_rom u_rom (
    .i_sel   (r_sel),
    .i_step  (r_step),
    .o_stage (w_rom_stage),
    .o_value (w_rom_value),
    .o_last  (w_rom_last)
  );

  // Rising-edge detection for start and timer expiry (prev updated every cycle)
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_start_prev <= 1'b0;
      r_start_edge <= 1'b0;
      r_exp_prev   <= 1'b0;
      r_exp_edge   <= 1'b0;
    end else begin
      r_start_prev <= btn_start;
      r_start_edge <= btn_start & ~r_start_prev;
      r_exp_prev   <= t_expired;
      r_exp_edge   <= t_expired & ~r_exp_prev;
    end
  end

`ifdef CANCEL_EN
  logic r_cancel_prev;
  logic r_cancel_edge;

  // Rising-edge detection for cancel
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_cancel_prev <= 1'b0;
      r_cancel_edge <= 1'b0;
    end else begin
      r_cancel_prev <= btn_cancel;
      r_cancel_edge <= btn_cancel & ~r_cancel_prev;
    end
  end

  assign w_cancel = r_cancel_edge & (r_state != ST_IDLE);
`else
  logic w_unused_cancel;
  assign w_unused_cancel = btn_cancel;
  assign w_cancel        = 1'b0;
`endif

  // Recipe FSM: step through the table, wait for expiry edges, hold done
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= SEL_ESPRESSO;
      r_step     <= 2'd0;
      r_done_cnt <= '0;
    end else if (w_cancel) begin
      // cancel wins over a simultaneous expiry edge
      r_state    <= ST_IDLE;
      r_step     <= 2'd0;
      r_done_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_start_edge) begin
            r_sel   <= coffee_sel;
            r_step  <= 2'd0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (r_exp_edge) begin
            if (w_rom_last) begin
              r_state    <= ST_DONE;
              r_done_cnt <= '0;
            end else begin
              r_step  <= r_step + 2'd1;
              r_state <= ST_LOAD;
            end
          end
        end
        default: begin
          if (r_done_cnt == LP_DONE_MAX) begin
            r_state    <= ST_IDLE;
            r_done_cnt <= '0;
          end else begin
            r_done_cnt <= r_done_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Moore outputs decoded from the state and the current table entry
  assign w_active    = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign start_timer = (r_state == ST_LOAD);
  assign value       = w_active ? w_rom_value : 2'd0;
  assign valve       = w_active ? stage_to_valve(w_rom_stage) : 4'b0000;
  assign stage       = w_active ? w_rom_stage :
                       ((r_state == ST_DONE) ? STG_DONE : STG_IDLE);
  assign busy        = w_active;
  assign done        = (r_state == ST_DONE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_brew_sequencer.sv
// tb_brew_sequencer: directed bench for brew_sequencer with DONE_CYCLES=8.
// Each scenario task drives stimulus and checks outputs against values
// worked out by hand from the recipe table and the two-cycle edge latency.
module tb_brew_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_cancel = 1'b0;
  logic [1:0] coffee_sel = 2'd0;
  logic       t_expired = 1'b0;
  logic       start_timer;
  logic [1:0] value;
  logic [3:0] valve;
  logic [2:0] stage;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int st_count = 0;
  int base;
  int n_done;

  brew_sequencer #(.DONE_CYCLES(8), .DONE_W(4)) dut (
    .clk_100MHz  (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_cancel  (btn_cancel),
    .coffee_sel  (coffee_sel),
    .t_expired   (t_expired),
    .start_timer (start_timer),
    .value       (value),
    .valve       (valve),
    .stage       (stage),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // start_timer pulse counter, sampled on the falling edge
  always @(negedge clk) if (!rst && start_timer) st_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset;
    btn_start = 1'b0; btn_cancel = 1'b0; t_expired = 1'b0; coffee_sel = 2'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick;
  endtask

  // rising start edge; returns in the LOAD cycle
  task automatic start_brew(input logic [1:0] s);
    coffee_sel = s; btn_start = 1'b1;
    tick;
    btn_start = 1'b0;
    tick;
  endtask

  // rising expiry edge from RUN; returns in the following LOAD or DONE cycle
  task automatic expire;
    t_expired = 1'b1;
    tick;
    t_expired = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (start_timer !== 1'b0) begin n_fail++; $display("FAIL rst_start_timer: got %b want 0", start_timer); end
    n_cmp++; if (value !== 2'd0) begin n_fail++; $display("FAIL rst_value: got %0d want 0", value); end
    n_cmp++; if (valve !== 4'b0000) begin n_fail++; $display("FAIL rst_valve: got %b want 0000", valve); end
    n_cmp++; if (stage !== 3'd0) begin n_fail++; $display("FAIL rst_stage: got %0d want 0", stage); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick;
  endtask

  task automatic test_espresso;
    base = st_count;
    coffee_sel = 2'd0; btn_start = 1'b1;
    tick;
    n_cmp++; if (start_timer !== 1'b0) begin n_fail++; $display("FAIL esp_latency_early: got %b want 0", start_timer); end
    btn_start = 1'b0;
    tick;
    n_cmp++; if (start_timer !== 1'b1) begin n_fail++; $display("FAIL esp_load0_pulse: got %b want 1", start_timer); end
    n_cmp++; if (value !== 2'd1) begin n_fail++; $display("FAIL esp_load0_value: got %0d want 1", value); end
    n_cmp++; if (valve !== 4'b0001) begin n_fail++; $display("FAIL esp_load0_valve: got %b want 0001", valve); end
    n_cmp++; if (stage !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL esp_load0_stage_busy: got %0d/%b want 1/1", stage, busy); end
    tick;
    n_cmp++; if (start_timer !== 1'b0 || value !== 2'd1) begin n_fail++; $display("FAIL esp_run0: got st=%b val=%0d want st=0 val=1", start_timer, value); end
    expire;
    n_cmp++; if (start_timer !== 1'b1 || value !== 2'd2) begin n_fail++; $display("FAIL esp_load1: got st=%b val=%0d want st=1 val=2", start_timer, value); end
    n_cmp++; if (valve !== 4'b0010 || stage !== 3'd2) begin n_fail++; $display("FAIL esp_load1_valve: got %b/%0d want 0010/2", valve, stage); end
    tick;
    expire;
    n_cmp++; if (done !== 1'b1 || stage !== 3'd5) begin n_fail++; $display("FAIL esp_done: got done=%b stage=%0d want 1/5", done, stage); end
    n_cmp++; if (valve !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL esp_done_valve: got %b busy=%b want 0000/0", valve, busy); end
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) n_done++;
      tick;
    end
    n_cmp++; if (n_done !== 8) begin n_fail++; $display("FAIL esp_done_len: got %0d want 8", n_done); end
    n_cmp++; if (stage !== 3'd0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL esp_back_idle: got stage=%0d state=%0d want 0/0", stage, dbg_state); end
    n_cmp++; if (st_count - base !== 2) begin n_fail++; $display("FAIL esp_pulses: got %0d want 2", st_count - base); end
  endtask

  task automatic test_mocha;
    apply_reset;
    base = st_count;
    start_brew(2'd3);
    n_cmp++; if (value !== 2'd1 || valve !== 4'b0001 || stage !== 3'd1) begin n_fail++; $display("FAIL mocha_s0: got %0d/%b/%0d want 1/0001/1", value, valve, stage); end
    tick;
    expire;
    n_cmp++; if (value !== 2'd2 || valve !== 4'b0010 || stage !== 3'd2) begin n_fail++; $display("FAIL mocha_s1: got %0d/%b/%0d want 2/0010/2", value, valve, stage); end
    tick;
    expire;
    n_cmp++; if (value !== 2'd1 || valve !== 4'b1000 || stage !== 3'd4) begin n_fail++; $display("FAIL mocha_s2: got %0d/%b/%0d want 1/1000/4", value, valve, stage); end
    tick;
    expire;
    n_cmp++; if (value !== 2'd2 || valve !== 4'b0100 || stage !== 3'd3) begin n_fail++; $display("FAIL mocha_s3: got %0d/%b/%0d want 2/0100/3", value, valve, stage); end
    tick;
    expire;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL mocha_done: got %b want 1", done); end
    n_cmp++; if (st_count - base !== 4) begin n_fail++; $display("FAIL mocha_pulses: got %0d want 4", st_count - base); end
    repeat (12) tick;
  endtask

  task automatic test_latte_sel_change;
    apply_reset;
    base = st_count;
    start_brew(2'd2);
    tick;
    coffee_sel = 2'd0;
    btn_start = 1'b1;
    tick;
    btn_start = 1'b0;
    tick;
    n_cmp++; if (start_timer !== 1'b0 || value !== 2'd1 || stage !== 3'd1) begin n_fail++; $display("FAIL latte_start_in_run: got st=%b val=%0d stage=%0d want 0/1/1", start_timer, value, stage); end
    expire;
    n_cmp++; if (value !== 2'd2) begin n_fail++; $display("FAIL latte_s1_value: got %0d want 2", value); end
    tick;
    expire;
    n_cmp++; if (value !== 2'd3 || stage !== 3'd3 || valve !== 4'b0100) begin n_fail++; $display("FAIL latte_s2: got %0d/%0d/%b want 3/3/0100", value, stage, valve); end
    tick;
    expire;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL latte_done: got %b want 1", done); end
    n_cmp++; if (st_count - base !== 3) begin n_fail++; $display("FAIL latte_pulses: got %0d want 3", st_count - base); end
    repeat (12) tick;
  endtask

  task automatic test_held_start;
    apply_reset;
    base = st_count;
    coffee_sel = 2'd0; btn_start = 1'b1;
    tick;
    tick;
    n_cmp++; if (start_timer !== 1'b1) begin n_fail++; $display("FAIL held_first_load: got %b want 1", start_timer); end
    tick;
    expire;
    tick;
    expire;
    repeat (20) tick;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL held_no_retrigger: got busy=%b done=%b state=%0d want 0/0/0", busy, done, dbg_state); end
    n_cmp++; if (st_count - base !== 2) begin n_fail++; $display("FAIL held_pulses: got %0d want 2", st_count - base); end
    btn_start = 1'b0;
    repeat (3) tick;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_release_idle: got %b want 0", busy); end
    btn_start = 1'b1;
    tick;
    tick;
    n_cmp++; if (start_timer !== 1'b1 || st_count - base !== 2) begin n_fail++; $display("FAIL held_new_edge: got st=%b pulses=%0d want 1/2", start_timer, st_count - base); end
    btn_start = 1'b0;
    tick;
  endtask

  task automatic test_stuck_expiry;
    apply_reset;
    base = st_count;
    coffee_sel = 2'd0; btn_start = 1'b1;
    tick;
    btn_start = 1'b0; t_expired = 1'b1;
    tick;
    n_cmp++; if (start_timer !== 1'b1 || value !== 2'd1) begin n_fail++; $display("FAIL stuck_load: got st=%b val=%0d want 1/1", start_timer, value); end
    repeat (21) tick;
    n_cmp++; if (value !== 2'd1 || stage !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL stuck_hold: got val=%0d stage=%0d busy=%b want 1/1/1", value, stage, busy); end
    n_cmp++; if (st_count - base !== 1) begin n_fail++; $display("FAIL stuck_pulses: got %0d want 1", st_count - base); end
    t_expired = 1'b0;
    tick;
    expire;
    n_cmp++; if (start_timer !== 1'b1 || value !== 2'd2) begin n_fail++; $display("FAIL stuck_reedge: got st=%b val=%0d want 1/2", start_timer, value); end
  endtask

  task automatic test_async_reset;
    apply_reset;
    start_brew(2'd3);
    tick;
    tick;
    n_cmp++; if (busy !== 1'b1 || valve !== 4'b0001) begin n_fail++; $display("FAIL arst_pre: got busy=%b valve=%b want 1/0001", busy, valve); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (valve !== 4'b0000 || value !== 2'd0 || stage !== 3'd0) begin n_fail++; $display("FAIL arst_outputs: got %b/%0d/%0d want 0000/0/0", valve, value, stage); end
    n_cmp++; if (busy !== 1'b0 || start_timer !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL arst_flags: got %b%b%b want 000", busy, start_timer, done); end
    tick;
    rst = 1'b0;
    tick;
  endtask

`ifdef CANCEL_EN
  task automatic test_cancel;
    apply_reset;
    base = st_count;
    start_brew(2'd0);
    tick;
    expire;
    tick;
    n_cmp++; if (valve !== 4'b0010 || busy !== 1'b1) begin n_fail++; $display("FAIL cancel_pre: got %b/%b want 0010/1", valve, busy); end
    btn_cancel = 1'b1;
    tick;
    btn_cancel = 1'b0;
    tick;
    n_cmp++; if (valve !== 4'b0000 || busy !== 1'b0 || start_timer !== 1'b0 || stage !== 3'd0) begin n_fail++; $display("FAIL cancel_idle: got valve=%b busy=%b st=%b stage=%0d want 0000/0/0/0", valve, busy, start_timer, stage); end
    repeat (5) tick;
    n_cmp++; if (st_count - base !== 2 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL cancel_no_pulse: got pulses=%0d state=%0d want 2/0", st_count - base, dbg_state); end
  endtask
`endif

  initial begin
    test_reset;
    test_espresso;
    test_mocha;
    test_latte_sel_change;
    test_held_start;
    test_stuck_expiry;
    test_async_reset;
`ifdef CANCEL_EN
    test_cancel;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
- Recipe controller that drives the brew timer's start/duration interface and consumes its expiry flag.
- Sequences the valves for the selected coffee type, one stage at a time, and waits for the timer between stages.
- Sits between the debounced front-panel buttons and the temporizador.
- Its outputs feed the valve drivers, the status LEDs and the seven-segment stage display.

Parameters:
- DONE_CYCLES, 100_000_000: number of clk_100MHz cycles that `done` is held after a completed brew (1 s).
- DONE_W, 27: width of the done-hold counter. Must satisfy 2^DONE_W > DONE_CYCLES.

Ports:
- clk_100MHz  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- btn_start  input  1  debounced start level; only its rising edge is used.
- btn_cancel  input  1  debounced cancel level; used only with CANCEL_EN.
- coffee_sel  input  2  recipe select: 0 espresso, 1 americano, 2 latte, 3 mocha.
- t_expired  input  1  timer expiry flag from temporizador.
- start_timer  output  1  one-cycle pulse that starts the timer.
- value  output  2  timer duration code, held stable for the whole stage.
- valve  output  4  one-hot valve enable: [0] water, [1] coffee, [2] milk, [3] chocolate.
- stage  output  3  current stage code for the display: 0 idle, 1 water, 2 coffee, 3 milk, 4 chocolate, 5 done.
- busy  output  1  high in LOAD and RUN.
- done  output  1  high throughout DONE.

Behaviour:
- Reset: state IDLE, step 0, all outputs 0, edge registers cleared. Reset mid-brew drops all valves in the same cycle and needs no timer cleanup.
- Edge detection: registered previous values of btn_start and t_expired. start_edge = btn_start & ~prev; exp_edge = t_expired & ~prev.
- Recipe table (stage/value per step):
  - espresso: water/1, coffee/2.
  - americano: water/3, coffee/2.
  - latte: water/1, coffee/2, milk/3.
  - mocha: water/1, coffee/2, chocolate/1, milk/2.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Outputs zero.
  - On start_edge: latch coffee_sel into sel_q, set step = 0, go to LOAD.
- LOAD (one cycle):
  - value and valve come from the table entry (sel_q, step).
  - start_timer = 1; stage = table stage; go to RUN.
- RUN:
  - start_timer = 0; value and valve are held.
  - On exp_edge: if this is the recipe's last step, go to DONE; otherwise step++ and go to LOAD.
  - An edge on the same cycle as LOAD's start_timer is ignored, because prev is updated regardless.
- DONE:
  - valve = 0, stage = 5, done = 1, counter counts from 0.
  - At count == DONE_CYCLES-1: go to IDLE with counter cleared.
- Latency:
  - start_edge → start_timer: 2 cycles (edge register, then LOAD).
  - exp_edge → next start_timer: 2 cycles.
- Boundaries:
  - start_edge outside IDLE is ignored.
  - coffee_sel changes after latching are ignored.
  - A held btn_start does not retrigger a brew after DONE; a new rising edge is needed.
  - t_expired stuck high produces no extra edges.
  - step never exceeds 3.
  - value never changes while in RUN.

Optional Feature:
- Macro: CANCEL_EN.
- Defined:
  - A rising edge of btn_cancel in LOAD, RUN or DONE forces IDLE on the next cycle, with all outputs 0 and no start_timer pulse.
  - A cancel edge on the same cycle as exp_edge has priority over the expiry.
  - Cancel in IDLE has no effect.
- Undefined: btn_cancel is ignored and no edge register is synthesised; the port remains for a fixed top-level.

Decomposition:
- Package brew_pkg holds:
  - state encoding (IDLE/LOAD/RUN/DONE);
  - stage codes (0–5);
  - valve bit indices;
  - coffee_sel codes;
  - recipe lengths {2,2,3,4}.
- Sub-module brew_recipe_rom: combinational lookup (sel, step) → stage[2:0], value[1:0], last.

Test Plan:
- Reset then espresso, DONE_CYCLES=8: start edge → start_timer pulse, value=1, valve=0001. Expiry edge → value=2, valve=0010. Expiry → done high for exactly 8 cycles, then IDLE.
- Mocha: four expiries give value sequence 1,2,1,2 and valve 0001, 0010, 1000, 0100, with stage 1, 2, 4, 3. Exactly 4 start_timer pulses.
- coffee_sel changed from 2 to 0 during RUN of latte: still 3 stages, last value=3.
- btn_start held high through DONE and then low: no second brew. A new rising edge starts one.
- t_expired held high across LOAD and 20 RUN cycles: no advance until it falls and rises again.
- CANCEL_EN: cancel edge in RUN of step 1 → next cycle IDLE, valve=0, busy=0, no start_timer. Async rst mid-RUN → all outputs 0 immediately.
